// File: rtl/jtag_scan_sequencer_if.sv
// Command/response port bundle for jtag_scan_sequencer.
// Defining JTAG_SEQ_RUNTEST_EN adds cmd_rti, the run-test/idle cycle count.
interface jtag_scan_sequencer_if #(
  parameter int MAXLEN = 32,
  parameter int LENW   = $clog2(MAXLEN + 1)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_ir;
  logic [LENW-1:0]   cmd_len;
  logic [MAXLEN-1:0] cmd_wdata;
`ifdef JTAG_SEQ_RUNTEST_EN
  logic [7:0]        cmd_rti;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MAXLEN-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_ir, cmd_len, cmd_wdata,
`ifdef JTAG_SEQ_RUNTEST_EN
    output cmd_rti,
`endif
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_len, cmd_wdata,
`ifdef JTAG_SEQ_RUNTEST_EN
    input  cmd_rti,
`endif
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG scan sequencer: turns IR/DR scan commands into a registered tms/tdi
// stream and collects tdo into a response word. Optional RTI hold: JTAG_SEQ_RUNTEST_EN.
module jtag_scan_sequencer #(
  parameter int MAXLEN = 32,
  parameter int LENW   = $clog2(MAXLEN + 1)
) (
  input  logic                  tck,
  input  logic                  trst,
  jtag_scan_sequencer_if.slave  bus,
  output logic                  tap_tms,
  output logic                  tap_tdi,
  input  logic                  tap_tdo,
  output logic                  busy
);

  // Each state names the TAP cycle currently being driven on tms/tdi.
  localparam logic [3:0] S_TLR         = 4'd0;
  localparam logic [3:0] S_IDLE        = 4'd1;
  localparam logic [3:0] S_SEL_DR      = 4'd2;
  localparam logic [3:0] S_SEL_IR      = 4'd3;
  localparam logic [3:0] S_CAPTURE     = 4'd4;
  localparam logic [3:0] S_SHIFT_ENTRY = 4'd5;
  localparam logic [3:0] S_SHIFT       = 4'd6;
  localparam logic [3:0] S_UPDATE      = 4'd7;
  localparam logic [3:0] S_TO_IDLE     = 4'd8;
  localparam logic [3:0] S_RESP        = 4'd9;
`ifdef JTAG_SEQ_RUNTEST_EN
  localparam logic [3:0] S_RTI         = 4'd10;
`endif

  localparam logic [LENW-1:0] LEN_MAX = LENW'(MAXLEN);

  logic [3:0]        state_q, state_d;
  logic [2:0]        tlr_cnt_q, tlr_cnt_d;
  logic              ir_q, ir_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   idx_q, idx_d;
  logic [MAXLEN-1:0] shift_q, shift_d;
  logic [MAXLEN-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
`ifdef JTAG_SEQ_RUNTEST_EN
  logic [7:0]        rti_q, rti_d;
  logic [7:0]        rti_cnt_q, rti_cnt_d;
`endif

  logic cmd_ready_w;
  logic accept;

  assign cmd_ready_w = (state_q == S_IDLE) && !rsp_valid_q;
  assign accept      = bus.cmd_valid && cmd_ready_w;

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign tap_tms       = tms_q;
  assign tap_tdi       = tdi_q;
  assign busy          = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    tlr_cnt_d   = tlr_cnt_q;
    ir_d        = ir_q;
    len_d       = len_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rsp_valid_d = rsp_valid_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
`ifdef JTAG_SEQ_RUNTEST_EN
    rti_d       = rti_q;
    rti_cnt_d   = rti_cnt_q;
`endif

    case (state_q)
      S_TLR: begin
        // Five tms=1 cycles reach Test-Logic-Reset from anywhere, one tms=0 enters Idle.
        if (tlr_cnt_q == 3'd6) begin
          state_d = S_IDLE;
        end else begin
          tlr_cnt_d = tlr_cnt_q + 3'd1;
          tms_d     = (tlr_cnt_q < 3'd5);
        end
      end

      S_IDLE: begin
        if (accept) begin
          state_d = S_SEL_DR;
          tms_d   = 1'b1;
          ir_d    = bus.cmd_ir;
          len_d   = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
          shift_d = bus.cmd_wdata;
          idx_d   = '0;
`ifdef JTAG_SEQ_RUNTEST_EN
          rti_d   = bus.cmd_rti;
`endif
        end
      end

      S_SEL_DR: begin
        if (ir_q) begin
          state_d = S_SEL_IR;
          tms_d   = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_SEL_IR: state_d = S_CAPTURE;

      S_CAPTURE: begin
        // A zero-length scan leaves Capture straight for Exit1 instead of Shift.
        state_d = S_SHIFT_ENTRY;
        tms_d   = (len_q == '0);
      end

      S_SHIFT_ENTRY: begin
        if (len_q == '0) begin
          state_d = S_UPDATE;
          tms_d   = 1'b1;
        end else begin
          state_d = S_SHIFT;
          idx_d   = '0;
          tdi_d   = shift_q[0];
          shift_d = shift_q >> 1;
          tms_d   = (len_q == LENW'(1));
        end
      end

      S_SHIFT: begin
        if (idx_q == len_q - LENW'(1)) begin
          state_d = S_UPDATE;
          tms_d   = 1'b1;
        end else begin
          idx_d   = idx_q + LENW'(1);
          tdi_d   = shift_q[0];
          shift_d = shift_q >> 1;
          tms_d   = ((idx_q + LENW'(2)) == len_q);
        end
      end

      S_UPDATE: state_d = S_TO_IDLE;

      S_TO_IDLE: begin
`ifdef JTAG_SEQ_RUNTEST_EN
        if (rti_q != 8'd0) begin
          state_d   = S_RTI;
          rti_cnt_d = rti_q;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
`else
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
`endif
      end

`ifdef JTAG_SEQ_RUNTEST_EN
      S_RTI: begin
        rti_cnt_d = rti_cnt_q - 8'd1;
        if (rti_cnt_q == 8'd1) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
`endif

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_TLR;
        tlr_cnt_d = '0;
        tms_d     = 1'b1;
      end
    endcase
  end

  // Per-bit tdo capture: bit i is written only at the edge ending shift cycle i.
  for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_rdata
    assign rdata_d[gi] = accept ? 1'b0 :
                         ((state_q == S_SHIFT) && (idx_q == LENW'(gi))) ? tap_tdo :
                         rdata_q[gi];
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q     <= S_TLR;
      tlr_cnt_q   <= '0;
      ir_q        <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
`ifdef JTAG_SEQ_RUNTEST_EN
      rti_q       <= '0;
      rti_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tlr_cnt_q   <= tlr_cnt_d;
      ir_q        <= ir_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
`ifdef JTAG_SEQ_RUNTEST_EN
      rti_q       <= rti_d;
      rti_cnt_q   <= rti_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer: table of scans with hand-computed tms/tdi
// streams, response cycle and rdata, plus reset, stall and mid-scan reset sequences.
module tb_jtag_scan_sequencer;
  localparam int MAXLEN = 32;
  localparam int LENW   = $clog2(MAXLEN + 1);

  typedef struct {
    logic              ir;
    logic [LENW-1:0]   len;
    logic [31:0]       wdata;
    logic [31:0]       tdo_pat;   // tdo the bench TAP returns in shift cycle i
    int                nshift;
    int                ncyc;      // cycles driven after accept
    logic [63:0]       exp_tms;   // bit k = tms in cycle k+1
    logic [63:0]       exp_tdi;
    int                exp_rsp;   // cycle in which rsp_valid is first seen
    logic [31:0]       exp_rdata;
    bit                hold_valid;
    bit                early_ready;
  } vec_t;

  logic tck = 1'b0;
  logic trst = 1'b0;
  logic tap_tms, tap_tdi, busy;
  logic tap_tdo = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  jtag_scan_sequencer_if #(.MAXLEN(MAXLEN), .LENW(LENW)) bus_if();

  jtag_scan_sequencer #(.MAXLEN(MAXLEN), .LENW(LENW)) dut (
    .tck     (tck),
    .trst    (trst),
    .bus     (bus_if),
    .tap_tms (tap_tms),
    .tap_tdi (tap_tdi),
    .tap_tdo (tap_tdo),
    .busy    (busy)
  );

  always #5 tck = ~tck;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, input int len, input logic [31:0] wdata,
                              input logic [31:0] tdo_pat, input int nshift, input int ncyc,
                              input logic [63:0] exp_tms, input logic [63:0] exp_tdi,
                              input int exp_rsp, input logic [31:0] exp_rdata,
                              input bit hold_valid, input bit early_ready);
    vec_t v;
    v.ir = ir; v.len = LENW'(len); v.wdata = wdata; v.tdo_pat = tdo_pat;
    v.nshift = nshift; v.ncyc = ncyc; v.exp_tms = exp_tms; v.exp_tdi = exp_tdi;
    v.exp_rsp = exp_rsp; v.exp_rdata = exp_rdata;
    v.hold_valid = hold_valid; v.early_ready = early_ready;
    return v;
  endfunction

  // Checks the post-reset walk: tms 1,1,1,1,1,0 in cycles 1..6, cmd_ready first in cycle 7.
  task automatic tlr_check(input string tag);
    logic [63:0] got_tms = '0;
    logic [63:0] got_rdy = '0;
    logic        any_tdi = 1'b0;
    logic        any_rsp = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge tck);
      @(negedge tck);
      if (c <= 6) got_tms[c-1] = tap_tms;
      got_rdy[c-1] = bus_if.cmd_ready;
      any_tdi |= tap_tdi;
      any_rsp |= bus_if.rsp_valid;
    end
    check({tag, "_tlr_tms"}, got_tms, 64'h1F);
    check({tag, "_tlr_ready"}, got_rdy, 64'h40);
    check({tag, "_tlr_tdi"}, {63'd0, any_tdi}, 64'd0);
    check({tag, "_tlr_rsp_valid"}, {63'd0, any_rsp}, 64'd0);
    $display("txn %s: TLR walk tms=0x%0h ready=0x%0h", tag, got_tms, got_rdy);
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge tck);
      if (bus_if.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: cmd_ready=%b required 1", tag, bus_if.cmd_ready);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit stall);
    logic [63:0] got_tms = '0;
    logic [63:0] got_tdi = '0;
    int          extra = 0;
    int          c;
    int          first;
    int          rsp_c = -1;
    int          bad = 0;
    bit          ok;
    string       tag;
    tag = $sformatf("v%0d", idx);
    first = v.ir ? 5 : 4;

    wait_ready(tag, ok);
    if (!ok) return;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_ir    = v.ir;
    bus_if.cmd_len   = v.len;
    bus_if.cmd_wdata = v.wdata;
    bus_if.rsp_ready = v.early_ready;
    @(posedge tck);
    #1;
    if (!v.hold_valid) bus_if.cmd_valid = 1'b0;
    c = 1;
    forever begin
      // Junk tdo outside shift cycles exposes sampling in the wrong cycle.
      if (c >= first && c < first + v.nshift) tap_tdo = v.tdo_pat[c - first];
      else tap_tdo = 1'b1;
      @(negedge tck);
      if (c <= v.ncyc) begin
        got_tms[c-1] = tap_tms;
        got_tdi[c-1] = tap_tdi;
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) extra++;
      if (bus_if.rsp_valid === 1'b1) begin
        rsp_c = c;
        break;
      end
      if (c >= 100) begin
        checks++;
        errors++;
        $display("FAIL %s_rsp_timeout: rsp_valid=%b required 1 within 100 cycles", tag, bus_if.rsp_valid);
        break;
      end
      @(posedge tck);
      #1;
      c++;
    end
    bus_if.cmd_valid = 1'b0;
    tap_tdo = 1'b1;

    check({tag, "_tms"}, got_tms, v.exp_tms);
    check({tag, "_tdi"}, got_tdi, v.exp_tdi);
    check({tag, "_rsp_cycle"}, 64'(rsp_c), 64'(v.exp_rsp));
    check({tag, "_rdata"}, 64'(bus_if.rsp_rdata), 64'(v.exp_rdata));
    check({tag, "_no_reaccept"}, 64'(extra), 64'd0);
    $display("txn %s: ir=%0d len=%0d wdata=0x%0h rsp_cycle=%0d rdata=0x%0h",
             tag, v.ir, v.len, v.wdata, rsp_c, bus_if.rsp_rdata);

    if (stall && rsp_c > 0) begin
      bus_if.rsp_ready = 1'b0;
      bus_if.cmd_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge tck);
        if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== v.exp_rdata ||
            bus_if.cmd_ready !== 1'b0) bad++;
      end
      bus_if.cmd_valid = 1'b0;
      check({tag, "_stall_stable"}, 64'(bad), 64'd0);
      $display("txn %s: held response 10 cycles, unstable cycles=%0d", tag, bad);
    end

    bus_if.rsp_ready = 1'b1;
    @(posedge tck);
    #1;
    bus_if.rsp_ready = 1'b0;
    check({tag, "_post_hs_valid_busy"}, {62'd0, bus_if.rsp_valid, busy}, 64'd0);
    check({tag, "_ready_after_hs"}, {63'd0, bus_if.cmd_ready}, 64'd1);
  endtask

  initial begin
    bit ok;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_ir    = 1'b0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b0;
`ifdef JTAG_SEQ_RUNTEST_EN
    bus_if.cmd_rti   = 8'd0;
`endif

    //            ir    len wdata         tdo_pat       nsh ncyc exp_tms              exp_tdi              rsp rdata         hold early
    vecs[0] = mk(1'b0,  1, 32'h1,        32'h0,         1,  6, 64'h19,              64'h08,               7, 32'h0,         0, 0);
    vecs[1] = mk(1'b1,  2, 32'h1,        32'h1,         2,  8, 64'h63,              64'h10,               9, 32'h1,         0, 0);
    vecs[2] = mk(1'b0,  0, 32'hFFFFFFFF, 32'hFFFFFFFF,  0,  5, 64'h0D,              64'h00,               6, 32'h0,         0, 1);
    vecs[3] = mk(1'b0,  8, 32'hA5,       32'h3C,        8, 13, 64'h0C01,            64'h528,             14, 32'h3C,        0, 0);
    vecs[4] = mk(1'b1,  5, 32'h16,       32'h09,        5, 11, 64'h303,             64'h160,             12, 32'h09,        0, 0);
    vecs[5] = mk(1'b0, 40, 32'hDEADBEEF, 32'h12345678, 32, 37, 64'hC_0000_0001,     64'h6_F56D_F778,     38, 32'h12345678,  1, 0);

    // Held in reset: outputs at their reset values.
    repeat (3) @(posedge tck);
    @(negedge tck);
    check("rst_tms_tdi", {62'd0, tap_tms, tap_tdi}, 64'h2);
    check("rst_ready_valid", {62'd0, bus_if.cmd_ready, bus_if.rsp_valid}, 64'h0);
    check("rst_rdata", 64'(bus_if.rsp_rdata), 64'h0);
    check("rst_busy", {63'd0, busy}, 64'h1);
    trst = 1'b1;
    tlr_check("init");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i], i == 3);

    // Reset pulsed mid-shift of a 16-bit DR scan: TLR walk restarts, no response.
    wait_ready("midrst", ok);
    if (ok) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_ir    = 1'b0;
      bus_if.cmd_len   = LENW'(16);
      bus_if.cmd_wdata = 32'h0000FFFF;
      @(posedge tck);
      #1;
      bus_if.cmd_valid = 1'b0;
      repeat (7) @(posedge tck);
      @(negedge tck);
      check("midrst_in_shift_tdi", {63'd0, tap_tdi}, 64'h1);
      trst = 1'b0;
      #1;
      check("midrst_abort", {60'd0, tap_tms, bus_if.rsp_valid, busy, bus_if.cmd_ready}, 64'hA);
      check("midrst_rdata", 64'(bus_if.rsp_rdata), 64'h0);
      $display("txn midrst: reset asserted in shift, tms=%b rsp_valid=%b", tap_tms, bus_if.rsp_valid);
      repeat (2) @(posedge tck);
      @(negedge tck);
      trst = 1'b1;
      tlr_check("midrst");
      run_vec(6, vecs[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
